// File: rtl/imem_arbiter.sv
// ---------------------------------------------------------------------------------------------
// imem_arbiter
//
// Shares the single-port 2K x 32 instruction RAM (RAM2Kx32) between the fetch stage and the
// program loader/debug port. One access is granted per cycle, combinationally from the current
// requests. Read data returns one cycle after the grant on the owner's rvalid. The loader can
// hold the RAM for an atomic burst with l_lock. A starvation counter can force a loader access
// through after STARVE_LIMIT consecutive denied cycles.
//
// Build option:
//   IMEM_ARB_STARVE_EN  defined   -> starvation counter and override are built.
//                       undefined -> strict fetch priority in NORMAL; STARVE_LIMIT is unused.
//
// Parameters:
//   ADDR_W        word address width (matches the RAM A pin)
//   DATA_W        data width
//   STARVE_LIMIT  denied loader cycles before the loader is forced through (1..255)
//
// Ports:
//   clk, rst_n                  rising-edge clock, synchronous active-low reset
//   f_req, f_addr               fetch read request and word address
//   f_gnt, f_rvalid, f_rdata    fetch grant, read-data valid, read data
//   l_req, l_we, l_lock         loader request, write(1)/read(0), burst lock
//   l_addr, l_wdata             loader word address and write data
//   l_gnt, l_rvalid, l_rdata    loader grant, read-data valid, read data
//   mem_cen, mem_wen, mem_oen   RAM active-low chip, write and output enables
//   mem_addr, mem_d             RAM address and write data
//   mem_q                       RAM read data, valid the cycle after a read edge
// ---------------------------------------------------------------------------------------------
module imem_arbiter #(
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // Fetch port
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  // Loader / debug port
  input  logic              l_req,
  input  logic              l_we,
  input  logic              l_lock,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  // RAM macro
  output logic              mem_cen,
  output logic              mem_wen,
  output logic              mem_oen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q
);

  // Reject out-of-range limits at elaboration; the counter is 8 bits wide.
  if (STARVE_LIMIT == 0 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
    $error("imem_arbiter: STARVE_LIMIT must be in 1..255");
  end

  typedef enum logic [0:0] {
    StNormal,
    StLocked
  } state_e;

  state_e state_q, state_d;
  logic   starve_override;

  // -------------------------------------------------------------------------------------------
  // Starvation counter
  // -------------------------------------------------------------------------------------------
`ifdef IMEM_ARB_STARVE_EN
  localparam logic [7:0] StarveLimit = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (l_gnt || !l_req) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != StarveLimit) begin
      // Saturate at the limit rather than wrapping.
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign starve_override = (starve_cnt_q == StarveLimit);
`else
  assign starve_override = 1'b0;
`endif

  // -------------------------------------------------------------------------------------------
  // Arbitration and ownership FSM
  // -------------------------------------------------------------------------------------------
  always_comb begin
    f_gnt   = 1'b0;
    l_gnt   = 1'b0;
    state_d = state_q;

    // No grants at all while reset is held, whatever the requests.
    if (rst_n) begin
      if (state_q == StLocked && l_lock) begin
        // Burst in progress: fetch is shut out entirely.
        l_gnt = l_req;
      end else if (l_req && starve_override) begin
        l_gnt = 1'b1;
      end else if (f_req) begin
        f_gnt = 1'b1;
      end else begin
        l_gnt = l_req;
      end
    end

    // Dropping l_lock in LOCKED returns to NORMAL and that same cycle already arbitrated as
    // NORMAL above. l_lock without a loader grant never enters LOCKED.
    case (state_q)
      StNormal: if (l_gnt && l_lock) state_d = StLocked;
      StLocked: if (!l_lock)         state_d = StNormal;
      default:                       state_d = StNormal;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StNormal;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------------------------
  // Read return tracking
  // -------------------------------------------------------------------------------------------
  logic rd_valid_q;
  logic rd_owner_q;  // 1: loader owns the returning read, 0: fetch

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      // Loader writes complete at the grant edge and return nothing.
      rd_valid_q <= f_gnt | (l_gnt & ~l_we);
      rd_owner_q <= l_gnt;
    end
  end

  // Qualifying with rst_n drops a read whose data would land in a reset cycle.
  assign f_rvalid = rst_n & rd_valid_q & ~rd_owner_q;
  assign l_rvalid = rst_n & rd_valid_q &  rd_owner_q;
  assign f_rdata  = mem_q;
  assign l_rdata  = mem_q;

  // -------------------------------------------------------------------------------------------
  // RAM drive
  // -------------------------------------------------------------------------------------------
  assign mem_cen  = ~(f_gnt | l_gnt);
  assign mem_wen  = ~(l_gnt & l_we);
  assign mem_oen  = 1'b0;
  assign mem_addr = f_gnt ? f_addr : (l_gnt ? l_addr : '0);
  assign mem_d    = l_gnt ? l_wdata : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;

  localparam int unsigned AW    = 11;
  localparam int unsigned DW    = 32;
  localparam int unsigned LIMIT = 4;
`ifdef IMEM_ARB_STARVE_EN
  localparam bit StarveEn = 1'b1;
`else
  localparam bit StarveEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          f_req, f_gnt, f_rvalid;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_rdata;
  logic          l_req, l_we, l_lock, l_gnt, l_rvalid;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata, l_rdata;
  logic          mem_cen, mem_wen, mem_oen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_d, mem_q;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] ram     [2048];
  logic [DW-1:0] ref_mem [2048];

  imem_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .f_req   (f_req),
    .f_addr  (f_addr),
    .f_gnt   (f_gnt),
    .f_rvalid(f_rvalid),
    .f_rdata (f_rdata),
    .l_req   (l_req),
    .l_we    (l_we),
    .l_lock  (l_lock),
    .l_addr  (l_addr),
    .l_wdata (l_wdata),
    .l_gnt   (l_gnt),
    .l_rvalid(l_rvalid),
    .l_rdata (l_rdata),
    .mem_cen (mem_cen),
    .mem_wen (mem_wen),
    .mem_oen (mem_oen),
    .mem_addr(mem_addr),
    .mem_d   (mem_d),
    .mem_q   (mem_q)
  );

  always #5 clk = ~clk;

  // RAM2Kx32 behavioural model driven by the DUT's pins.
  always @(posedge clk) begin
    if (!mem_cen) begin
      if (!mem_wen) ram[mem_addr] <= mem_d;
      else          mem_q <= ram[mem_addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic idle_inputs;
    f_req = 1'b0; f_addr = '0;
    l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0; l_addr = '0; l_wdata = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    f_req = 1'b1; f_addr = 11'h004;
    l_req = 1'b1; l_addr = 11'h008;
    for (int c = 0; c < 2; c++) begin
      settle;
      checks++;
      if (f_gnt !== 1'b0) begin failures++; $display("FAIL reset_f_gnt: got %b want 0", f_gnt); end
      checks++;
      if (l_gnt !== 1'b0) begin failures++; $display("FAIL reset_l_gnt: got %b want 0", l_gnt); end
      checks++;
      if (mem_cen !== 1'b1) begin failures++; $display("FAIL reset_cen: got %b want 1", mem_cen); end
      tick;
    end
    rst_n = 1'b1;
    settle;
    checks++;
    if (f_rvalid !== 1'b0) begin failures++; $display("FAIL rel_f_rvalid: got %b want 0", f_rvalid); end
    checks++;
    if (l_rvalid !== 1'b0) begin failures++; $display("FAIL rel_l_rvalid: got %b want 0", l_rvalid); end
    checks++;
    if (f_gnt !== 1'b1 || l_gnt !== 1'b0) begin
      failures++; $display("FAIL rel_first_gnt: got f=%b l=%b want f=1 l=0", f_gnt, l_gnt);
    end
    tick;
    idle_inputs;
    tick;
  endtask

  task automatic test_fetch_read;
    f_req = 1'b1; f_addr = 11'h004;
    settle;
    checks++;
    if (f_gnt !== 1'b1 || mem_cen !== 1'b0 || mem_addr !== 11'h004) begin
      failures++;
      $display("FAIL fetch_issue: got gnt=%b cen=%b addr=%h want 1 0 004", f_gnt, mem_cen, mem_addr);
    end
    tick;
    f_req = 1'b0;
    settle;
    checks++;
    if (f_rvalid !== 1'b1) begin failures++; $display("FAIL fetch_rvalid: got %b want 1", f_rvalid); end
    checks++;
    if (f_rdata !== ref_mem[4]) begin
      failures++; $display("FAIL fetch_rdata: got %h want %h", f_rdata, ref_mem[4]);
    end
    checks++;
    if (l_rvalid !== 1'b0) begin failures++; $display("FAIL fetch_l_rvalid: got %b want 0", l_rvalid); end
    tick;
  endtask

  task automatic test_starvation;
    logic exp_l;
    f_req = 1'b1; f_addr = 11'h010;
    l_req = 1'b1; l_we = 1'b0; l_lock = 1'b0; l_addr = 11'h011;
    for (int k = 0; k < 15; k++) begin
      exp_l = StarveEn && ((k % (LIMIT + 1)) == LIMIT);
      settle;
      checks++;
      if (l_gnt !== exp_l || f_gnt !== !exp_l) begin
        failures++;
        $display("FAIL starve_c%0d: got f=%b l=%b want f=%b l=%b", k, f_gnt, l_gnt, !exp_l, exp_l);
      end
      tick;
    end
    idle_inputs;
    tick;
  endtask

  task automatic test_locked_burst;
    for (int i = 0; i < 4; i++) begin
      // Loader takes the RAM on an idle fetch cycle, then fetch starts requesting.
      f_req   = (i != 0); f_addr = 11'h010;
      l_req   = 1'b1; l_we = 1'b1; l_lock = 1'b1;
      l_addr  = 11'h100 + 11'(i);
      l_wdata = 32'hDEADBEEF;
      settle;
      checks++;
      if (l_gnt !== 1'b1 || f_gnt !== 1'b0 || mem_wen !== 1'b0) begin
        failures++;
        $display("FAIL lock_w%0d: got l=%b f=%b wen=%b want 1 0 0", i, l_gnt, f_gnt, mem_wen);
      end
      checks++;
      if (mem_addr !== l_addr || mem_d !== 32'hDEADBEEF) begin
        failures++;
        $display("FAIL lock_bus%0d: got addr=%h d=%h want %h deadbeef", i, mem_addr, mem_d, l_addr);
      end
      tick;
      ref_mem[11'h100 + 11'(i)] = 32'hDEADBEEF;
    end
    l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0;
    f_req = 1'b1; f_addr = 11'h101;
    settle;
    checks++;
    if (f_gnt !== 1'b1 || mem_addr !== 11'h101) begin
      failures++; $display("FAIL unlock_fetch: got gnt=%b addr=%h want 1 101", f_gnt, mem_addr);
    end
    tick;
    f_req = 1'b0;
    settle;
    checks++;
    if (f_rvalid !== 1'b1 || f_rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL lock_readback: got v=%b d=%h want 1 deadbeef", f_rvalid, f_rdata);
    end
    tick;
  endtask

  task automatic test_reset_mid_read;
    l_req = 1'b1; l_we = 1'b0; l_addr = 11'h020;
    settle;
    checks++;
    if (l_gnt !== 1'b1) begin failures++; $display("FAIL midrst_gnt: got %b want 1", l_gnt); end
    tick;
    rst_n = 1'b0;
    idle_inputs;
    settle;
    checks++;
    if (l_rvalid !== 1'b0) begin failures++; $display("FAIL midrst_rv0: got %b want 0", l_rvalid); end
    tick;
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      settle;
      checks++;
      if (l_rvalid !== 1'b0 || f_rvalid !== 1'b0) begin
        failures++; $display("FAIL midrst_after%0d: got l=%b f=%b want 0 0", c, l_rvalid, f_rvalid);
      end
      tick;
    end
  endtask

  task automatic test_idle;
    idle_inputs;
    for (int c = 0; c < 2; c++) begin
      settle;
      checks++;
      if (mem_cen !== 1'b1 || mem_wen !== 1'b1 || mem_addr !== '0 || mem_oen !== 1'b0) begin
        failures++;
        $display("FAIL idle_bus%0d: got cen=%b wen=%b oen=%b addr=%h want 1 1 0 000",
                 c, mem_cen, mem_wen, mem_oen, mem_addr);
      end
      checks++;
      if (f_rvalid !== 1'b0 || l_rvalid !== 1'b0) begin
        failures++; $display("FAIL idle_rv%0d: got f=%b l=%b want 0 0", c, f_rvalid, l_rvalid);
      end
      tick;
    end
  endtask

  // Random traffic against a cycle-level reference model of the arbitration rules.
  task automatic test_random(input int n);
    bit            m_locked, held, e_f, e_l, e_fv, e_lv, f_pend, l_pend;
    int            denied;
    logic [DW-1:0] e_data;
    logic [AW-1:0] e_addr;
    rst_n = 1'b0;
    idle_inputs;
    tick;
    rst_n = 1'b1;
    m_locked = 0; denied = 0; e_fv = 0; e_lv = 0; e_data = '0;
    f_pend = 0; l_pend = 0;
    for (int c = 0; c < n; c++) begin
      if (!f_pend && $urandom_range(0, 3) != 0) begin
        f_pend = 1; f_addr = 11'($urandom_range(0, 15));
      end
      if (!l_pend && $urandom_range(0, 2) == 0) begin
        l_pend  = 1;
        l_we    = 1'($urandom_range(0, 1));
        l_addr  = 11'($urandom_range(0, 15));
        l_wdata = $urandom;
      end
      f_req = f_pend;
      l_req = l_pend;
      if ($urandom_range(0, 3) == 0) l_lock = 1'($urandom_range(0, 1));
      settle;

      held = m_locked && l_lock;
      if (held)                                                  e_l = l_req;
      else if (l_req && StarveEn && denied >= int'(LIMIT))       e_l = 1;
      else                                                       e_l = l_req && !f_req;
      e_f    = !held && f_req && !e_l;
      e_addr = e_f ? f_addr : (e_l ? l_addr : '0);

      checks++;
      if (f_gnt !== e_f || l_gnt !== e_l) begin
        failures++;
        $display("FAIL rnd_gnt c%0d: got f=%b l=%b want f=%b l=%b", c, f_gnt, l_gnt, e_f, e_l);
      end
      checks++;
      if (mem_cen !== !(e_f || e_l) || mem_wen !== !(e_l && l_we) || mem_addr !== e_addr) begin
        failures++;
        $display("FAIL rnd_bus c%0d: got cen=%b wen=%b addr=%h want %b %b %h", c, mem_cen,
                 mem_wen, mem_addr, !(e_f || e_l), !(e_l && l_we), e_addr);
      end
      if (e_l && l_we) begin
        checks++;
        if (mem_d !== l_wdata) begin
          failures++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, mem_d, l_wdata);
        end
      end
      checks++;
      if (f_rvalid !== e_fv || l_rvalid !== e_lv) begin
        failures++;
        $display("FAIL rnd_rvalid c%0d: got f=%b l=%b want f=%b l=%b", c, f_rvalid, l_rvalid,
                 e_fv, e_lv);
      end
      if (e_fv) begin
        checks++;
        if (f_rdata !== e_data) begin
          failures++; $display("FAIL rnd_f_rdata c%0d: got %h want %h", c, f_rdata, e_data);
        end
      end
      if (e_lv) begin
        checks++;
        if (l_rdata !== e_data) begin
          failures++; $display("FAIL rnd_l_rdata c%0d: got %h want %h", c, l_rdata, e_data);
        end
      end
      tick;

      if (e_f || (e_l && !l_we)) e_data = ref_mem[e_addr];
      if (e_l && l_we) ref_mem[l_addr] = l_wdata;
      e_fv     = e_f;
      e_lv     = e_l && !l_we;
      denied   = (l_req && !e_l) ? ((denied < int'(LIMIT)) ? denied + 1 : denied) : 0;
      m_locked = l_lock && (m_locked || e_l);
      if (e_f) f_pend = 0;
      if (e_l) l_pend = 0;
    end
    idle_inputs;
    tick;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      ram[i]     = 32'(i) * 32'h9E3779B1 ^ 32'hA5A50000;
      ref_mem[i] = 32'(i) * 32'h9E3779B1 ^ 32'hA5A50000;
    end
    mem_q = '0;
    idle_inputs;
    rst_n = 1'b0;
    #1;
    test_reset;
    test_fetch_read;
    test_starvation;
    test_locked_burst;
    test_reset_mid_read;
    test_idle;
    test_random(800);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Arbitrates the single-port 2K×32 instruction RAM between two requesters. The fetch stage uses it for every PC read, and the program loader/debug port uses it to read and write program words. The block sits between the fetch stage and the RAM2Kx32 macro and drives the macro's active-low control pins directly. It grants one access per cycle, returns read data one cycle later, prevents loader starvation and supports a locked loader burst for atomic program loads.

## Interface
- ADDR_W, 11, word address width; matches the RAM2Kx32 A pin
- DATA_W, 32, data width
- STARVE_LIMIT, 8, consecutive denied loader cycles before the loader is forced through (range 1..255)

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- f_req  in  1  fetch read request
- f_addr  in  ADDR_W  fetch word address (pc[10:0])
- f_gnt  out  1  fetch access issued this cycle
- f_rvalid  out  1  fetch read data valid
- f_rdata  out  DATA_W  fetch read data
- l_req  in  1  loader request
- l_we  in  1  loader write (1) or read (0)
- l_lock  in  1  hold ownership for the loader burst
- l_addr  in  ADDR_W  loader word address
- l_wdata  in  DATA_W  loader write data
- l_gnt  out  1  loader access issued this cycle
- l_rvalid  out  1  loader read data valid
- l_rdata  out  DATA_W  loader read data
- mem_cen  out  1  RAM chip enable, active-low
- mem_wen  out  1  RAM write enable, active-low
- mem_oen  out  1  RAM output enable, active-low
- mem_addr  out  ADDR_W  RAM address
- mem_d  out  DATA_W  RAM write data
- mem_q  in  DATA_W  RAM read data, valid the cycle after a read edge

## Operation
- The grant is combinational from the current requests, the current FSM state and the starvation counter. At most one grant is asserted per cycle.
- FSM has two states, NORMAL and LOCKED.
  - NORMAL: f_req wins over l_req, unless the starvation override is active, in which case the loader wins.
  - NORMAL→LOCKED: on a cycle with l_gnt=1 and l_lock=1.
  - LOCKED: f_gnt is held at 0. l_gnt equals l_req.
  - LOCKED→NORMAL: on the first cycle sampled with l_lock=0. That cycle already arbitrates as NORMAL.
- Starvation counter (8 bits):
  - Increments on every cycle with l_req=1 and l_gnt=0.
  - Clears on l_gnt=1 or l_req=0.
  - Override is active when the counter equals STARVE_LIMIT.
- Memory drive:
  - mem_cen = 0 exactly when a grant is asserted; otherwise 1.
  - mem_wen = 0 only when l_gnt=1 and l_we=1.
  - mem_oen is tied to 0.
  - mem_addr and mem_d take the winner's address and data. When idle they are driven to 0.
- Read return:
  - A registered owner tag plus valid bit records each granted read.
  - The next cycle asserts f_rvalid or l_rvalid for one cycle.
  - f_rdata and l_rdata both pass mem_q through; each is qualified only by its own rvalid.
- Loader writes complete at the grant edge and produce no rvalid.

## Timing
- Grant latency: 0 cycles (same cycle as the request). Read data latency: 1 cycle after the grant.
- Requesters hold req, addr and data until they see their gnt. There is no backpressure on rvalid.
- Back-to-back grants to either port are allowed every cycle (full throughput).
- With rst_n=0 sampled:
  - state becomes NORMAL, the counter becomes 0, and f_rvalid and l_rvalid become 0.
  - A read that was in flight is discarded; no rvalid is produced for it.
  - While rst_n=0, f_gnt=l_gnt=0 and mem_cen=1, regardless of requests.
- Counter saturates at STARVE_LIMIT; it never wraps.
- l_lock asserted while l_req=0 has no effect in NORMAL.

## Configuration
- IMEM_ARB_STARVE_EN defined: the starvation counter and override are built as described above.
- IMEM_ARB_STARVE_EN undefined: no counter is built, and NORMAL uses strict fetch priority. The loader gets access only on idle fetch cycles or in LOCKED. STARVE_LIMIT is ignored.

## Test plan
- Reset: rst_n=0 for 2 cycles with both reqs high → f_gnt=l_gnt=0 and mem_cen=1. On release, both rvalids are 0 and the first grant goes to fetch.
- Fetch read: addr 0x004 at cycle N → f_gnt=1, mem_cen=0 and mem_addr=0x004 at N. At N+1, f_rvalid=1 and f_rdata equals the preloaded word.
- Starvation (STARVE_LIMIT=4, macro defined), f_req and l_req held high → grant pattern F,F,F,F,L repeating, with l_gnt on cycles 4, 9 and 14. With the macro undefined, l_gnt stays 0 throughout.
- Locked burst: loader writes 0xDEADBEEF to addrs 0x100–0x103 with l_lock=1 while f_req=1 → four l_gnt with mem_wen=0 and zero f_gnt. After l_lock drops, fetch is granted the next cycle. A fetch read of 0x101 then returns 0xDEADBEEF.
- Reset mid-read: loader read is granted at N and rst_n=0 at N+1 → l_rvalid stays 0 at N+1 and afterwards.
- Idle: both reqs low → mem_cen=1, mem_wen=1, mem_addr=0 and no rvalid.
